// File: rtl/mac_classifier_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mac_classifier_pkg                                           |
// | Description : Shared types and constants for the MAC classifier. Defines   |
// |               MAC, egress-port and tag types, the 8-bit tag word layout,   |
// |               the broadcast address and the FSM state encoding.            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package mac_classifier_pkg;

    typedef logic [47:0] mac_t;
    typedef logic [1:0]  port_t;
    typedef logic [5:0]  tag_t;

    // Egress interface sits in the upper two bits of the emitted tag.
    typedef struct packed {
        port_t port;
        tag_t  tag;
    } tag_word_t;

    localparam mac_t BCAST_MAC = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/mac_classifier_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mac_classifier_if                                            |
// | Description : Packet-stream and tag-stream bundle for the MAC classifier.  |
// |   in_data/in_valid/in_sop/in_eop/in_channel : packet beat (master->slave)  |
// |   in_ready                                  : beat accept (slave->master)  |
// |   tag_data/tag_valid                        : tag output (slave->master)   |
// |   tag_ready                                 : tag accept (master->slave)   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface mac_classifier_if;
    import mac_classifier_pkg::*;

    logic [63:0] in_data;
    logic        in_valid;
    logic        in_sop;
    logic        in_eop;
    tag_t        in_channel;
    logic        in_ready;
    tag_word_t   tag_data;
    logic        tag_valid;
    logic        tag_ready;

    modport master (
        output in_data, in_valid, in_sop, in_eop, in_channel,
        input  in_ready,
        input  tag_data, tag_valid,
        output tag_ready
    );

    modport slave (
        input  in_data, in_valid, in_sop, in_eop, in_channel,
        output in_ready,
        output tag_data, tag_valid,
        input  tag_ready
    );

endinterface
`default_nettype wire

// File: rtl/mac_classifier_tag_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tag_fifo                                                     |
// | Description : Small synchronous FIFO with registered full/empty flags.     |
// |   clock/reset  : clock, asynchronous active-low reset                      |
// |   i_push/i_push_data : write strobe and data (ignored when full)           |
// |   i_pop        : read strobe (ignored when empty)                          |
// |   o_head_data  : entry at the head, zero while empty                       |
// |   o_empty/o_full : registered occupancy flags                              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tag_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_push_data,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_head_data,
    output logic                  o_empty,
    output logic                  o_full
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic             r_empty;
    logic             r_full;
    logic [c_AW-1:0]  w_wr_ptr_nxt;
    logic [c_AW-1:0]  w_rd_ptr_nxt;
    logic             w_push;
    logic             w_pop;

    assign w_push       = i_push && !r_full;
    assign w_pop        = i_pop && !r_empty;
    // DEPTH is a power of two, so pointers wrap by natural overflow.
    assign w_wr_ptr_nxt = r_wr_ptr + 1'b1;
    assign w_rd_ptr_nxt = r_rd_ptr + 1'b1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= w_wr_ptr_nxt;
            if (w_pop)  r_rd_ptr <= w_rd_ptr_nxt;
            // Simultaneous push and pop keeps occupancy, so flags hold.
            if (w_push && !w_pop) begin
                r_empty <= 1'b0;
                r_full  <= (w_wr_ptr_nxt == r_rd_ptr);
            end else if (w_pop && !w_push) begin
                r_full  <= 1'b0;
                r_empty <= (w_rd_ptr_nxt == r_wr_ptr);
            end
        end
    end

    // Storage needs no reset: the empty flag masks stale contents.
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head_data = r_empty ? '0 : r_mem[r_rd_ptr];
    assign o_empty     = r_empty;
    assign o_full      = r_full;

endmodule
`default_nettype wire

// File: rtl/mac_classifier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mac_classifier                                               |
// | Description : Snoops a packet stream, looks up the destination MAC of each |
// |               packet in a programmable table and queues one tag           |
// |               {egress, channel} per packet after its eop beat.            |
// |   clock/reset   : clock, asynchronous active-low reset                     |
// |   bus           : packet input and tag output (slave side)                 |
// |   cfg_wr/cfg_index/cfg_en/cfg_mac/cfg_port : table write port             |
// |   stat_pkts/stat_miss : saturating classified / miss counters              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module mac_classifier
    import mac_classifier_pkg::*;
#(
    parameter int    NUM_ENTRIES  = 8,
    parameter int    FIFO_DEPTH   = 4,
    parameter port_t DEFAULT_PORT = 2'd0,
    parameter port_t BCAST_PORT   = 2'd3
) (
    input  wire logic                           clock,
    input  wire logic                           reset,
    mac_classifier_if.slave                     bus,
    input  wire logic                           cfg_wr,
    input  wire logic [$clog2(NUM_ENTRIES)-1:0] cfg_index,
    input  wire logic                           cfg_en,
    input  wire logic [47:0]                    cfg_mac,
    input  wire logic [1:0]                     cfg_port,
    output logic      [15:0]                    stat_pkts,
    output logic      [15:0]                    stat_miss
);

    localparam logic [0:0]  c_ST_IDLE   = IDLE;
    localparam logic [0:0]  c_ST_IN_PKT = IN_PKT;
    localparam logic [15:0] c_STAT_MAX  = 16'hFFFF;

    logic [NUM_ENTRIES-1:0] r_tbl_en;
    mac_t                   r_tbl_mac  [NUM_ENTRIES];
    port_t                  r_tbl_port [NUM_ENTRIES];

    logic [0:0]  r_state;
    tag_t        r_chan;
    port_t       r_port;
    logic        r_miss;
    logic [15:0] r_pkts;
    logic [15:0] r_misses;

    mac_t                   w_dst;
    logic                   w_accept;
    logic [NUM_ENTRIES-1:0] w_match;
    logic                   w_hit;
    port_t                  w_hit_port;
    logic                   w_bcast;
    port_t                  w_lk_port;
    logic                   w_lk_miss;
    logic                   w_push;
    tag_word_t              w_push_word;
    logic                   w_push_miss;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [7:0]             w_head;
    logic                   w_unused;

    assign w_dst    = bus.in_data[63:16];
    assign w_unused = ^bus.in_data[15:0];

    // Back-pressure depends only on registered FIFO state.
    assign bus.in_ready = !w_fifo_full;
    assign w_accept     = bus.in_valid && bus.in_ready;

    // Lookup reads the registered table, so a write landing on a sop cycle
    // only affects later packets.
    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_match
            assign w_match[gi] = r_tbl_en[gi] && (r_tbl_mac[gi] == w_dst);
        end
    endgenerate

    // Scan from the top so the lowest matching index is the last to win.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_port = DEFAULT_PORT;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_hit      = 1'b1;
                w_hit_port = r_tbl_port[i];
            end
        end
    end

    assign w_bcast   = (w_dst == BCAST_MAC);
    assign w_lk_port = w_bcast ? BCAST_PORT : w_hit_port;
    assign w_lk_miss = !w_bcast && !w_hit;

    // Single-beat packets push the live lookup; multi-beat packets push the
    // result captured at sop. An eop outside a packet is dropped.
    always_comb begin
        w_push      = 1'b0;
        w_push_word = '{port: r_port, tag: r_chan};
        w_push_miss = r_miss;
        if (w_accept && bus.in_eop) begin
            if (bus.in_sop) begin
                w_push      = 1'b1;
                w_push_word = '{port: w_lk_port, tag: bus.in_channel};
                w_push_miss = w_lk_miss;
            end else if (r_state == c_ST_IN_PKT) begin
                w_push = 1'b1;
            end
        end
    end

    // A sop always restarts classification, abandoning any open packet.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
            r_chan  <= '0;
            r_port  <= '0;
            r_miss  <= 1'b0;
        end else if (w_accept) begin
            if (bus.in_sop) begin
                r_chan  <= bus.in_channel;
                r_port  <= w_lk_port;
                r_miss  <= w_lk_miss;
                r_state <= bus.in_eop ? c_ST_IDLE : c_ST_IN_PKT;
            end else if (bus.in_eop) begin
                r_state <= c_ST_IDLE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tbl_en <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_tbl_mac[i]  <= '0;
                r_tbl_port[i] <= '0;
            end
        end else if (cfg_wr) begin
            r_tbl_en[cfg_index]   <= cfg_en;
            r_tbl_mac[cfg_index]  <= cfg_mac;
            r_tbl_port[cfg_index] <= cfg_port;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pkts   <= '0;
            r_misses <= '0;
        end else if (w_push) begin
            if (r_pkts != c_STAT_MAX)                r_pkts   <= r_pkts + 16'd1;
            if (w_push_miss && r_misses != c_STAT_MAX) r_misses <= r_misses + 16'd1;
        end
    end

    tag_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_push_word),
        .i_pop       (bus.tag_ready),
        .o_head_data (w_head),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full)
    );

    assign bus.tag_valid = !w_fifo_empty;
    assign bus.tag_data  = w_head;
    assign stat_pkts     = r_pkts;
    assign stat_miss     = r_misses;

endmodule
`default_nettype wire

// File: tb/tb_mac_classifier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mac_classifier                                            |
// | Description : Scoreboard bench for mac_classifier. Expected tags are       |
// |               queued by a packet-level reference model as beats are       |
// |               accepted; a monitor pops and compares on every tag handshake.|
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_mac_classifier;
    import mac_classifier_pkg::*;

    localparam int NE = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_wr = 1'b0;
    logic [2:0]  cfg_index = '0;
    logic        cfg_en = 1'b0;
    logic [47:0] cfg_mac = '0;
    logic [1:0]  cfg_port = '0;
    logic [15:0] stat_pkts;
    logic [15:0] stat_miss;

    mac_classifier_if bus();

    mac_classifier #(
        .NUM_ENTRIES  (NE),
        .FIFO_DEPTH   (4),
        .DEFAULT_PORT (2'd0),
        .BCAST_PORT   (2'd3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .cfg_wr    (cfg_wr),
        .cfg_index (cfg_index),
        .cfg_en    (cfg_en),
        .cfg_mac   (cfg_mac),
        .cfg_port  (cfg_port),
        .stat_pkts (stat_pkts),
        .stat_miss (stat_miss)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model state: table contents, open-packet record, counters.
    bit          m_en   [NE];
    logic [47:0] m_mac  [NE];
    logic [1:0]  m_port [NE];
    bit          m_in_pkt;
    logic [7:0]  m_pend;
    bit          m_pend_miss;
    int unsigned m_pkts;
    int unsigned m_miss;
    logic [7:0]  exp_q [$];
    logic [7:0]  mon_e;
    bit          rand_rdy = 1'b0;
    logic [47:0] pool [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void m_lookup(input logic [47:0] d, output logic [1:0] p, output bit miss);
        p    = 2'd0;
        miss = 1'b1;
        if (d == 48'hFFFF_FFFF_FFFF) begin
            p    = 2'd3;
            miss = 1'b0;
            return;
        end
        for (int i = 0; i < NE; i++) begin
            if (m_en[i] && m_mac[i] == d) begin
                p    = m_port[i];
                miss = 1'b0;
                return;
            end
        end
    endfunction

    function automatic void m_push(input logic [7:0] t, input bit miss);
        exp_q.push_back(t);
        if (m_pkts < 65535) m_pkts++;
        if (miss && m_miss < 65535) m_miss++;
    endfunction

    function automatic void m_accept(input logic [63:0] d, input bit s, input bit e, input logic [5:0] ch);
        logic [1:0] p;
        bit         miss;
        if (s) begin
            m_lookup(d[63:16], p, miss);
            if (e) begin
                m_push({p, ch}, miss);
                m_in_pkt = 1'b0;
            end else begin
                m_in_pkt    = 1'b1;
                m_pend      = {p, ch};
                m_pend_miss = miss;
            end
        end else if (e) begin
            if (m_in_pkt) m_push(m_pend, m_pend_miss);
            m_in_pkt = 1'b0;
        end
    endfunction

    function automatic void m_reset();
        exp_q.delete();
        m_in_pkt = 1'b0;
        m_pkts   = 0;
        m_miss   = 0;
        for (int i = 0; i < NE; i++) m_en[i] = 1'b0;
    endfunction

    // Monitor: one comparison per tag handshake.
    always @(negedge clock) begin
        if (reset && bus.tag_valid && bus.tag_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_tag: got %0h expected none", bus.tag_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("tag", bus.tag_data, mon_e);
            end
        end
    end

    always @(posedge clock) begin
        #1;
        if (rand_rdy) bus.tag_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic cfg_write(input int idx, input bit en, input logic [47:0] mac, input logic [1:0] port);
        cfg_wr = 1'b1; cfg_index = 3'(idx); cfg_en = en; cfg_mac = mac; cfg_port = port;
        @(posedge clock); #1;
        m_en[idx] = en; m_mac[idx] = mac; m_port[idx] = port;
        cfg_wr = 1'b0;
    endtask

    // Present one beat, wait (bounded) for acceptance, then update the model.
    task automatic send_beat(input logic [63:0] d, input bit s, input bit e, input logic [5:0] ch, input bit chk_rise);
        int n = 0;
        bus.in_data = d; bus.in_sop = s; bus.in_eop = e; bus.in_channel = ch; bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 300) begin @(posedge clock); #1; n++; end
        if (n >= 300) begin
            total++; bad++;
            $display("FAIL accept_timeout: in_ready=%b expected 1", bus.in_ready);
            bus.in_valid = 1'b0;
            return;
        end
        if (chk_rise) begin @(negedge clock); check("tag_valid_same_cycle", bus.tag_valid, 0); end
        @(posedge clock); #1;
        m_accept(d, s, e, ch);
        if (chk_rise) check("tag_valid_next_cycle", bus.tag_valid, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic check_stats();
        check("stat_pkts", stat_pkts, m_pkts);
        check("stat_miss", stat_miss, m_miss);
    endtask

    task automatic check_drained();
        int n = 0;
        while (exp_q.size() > 0 && n < 100) begin @(posedge clock); #1; n++; end
        check("queue_drained", exp_q.size(), 0);
        check("tag_valid_idle", bus.tag_valid, 0);
    endtask

    initial begin
        logic [63:0] d;
        m_reset();
        bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
        bus.in_data = '0; bus.in_channel = '0; bus.tag_ready = 1'b1;
        #1 reset = 1'b0;
        idle(3);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_tag_valid", bus.tag_valid, 0);
        check("rst_tag_data", bus.tag_data, 0);
        check_stats();
        reset = 1'b1;
        idle(1);

        // Known MAC, 3 beats, channel changes mid-packet.
        cfg_write(2, 1'b1, 48'h0011_2233_4455, 2'd2);
        send_beat({48'h0011_2233_4455, 16'h1234}, 1, 0, 6'd5, 0);
        send_beat(64'hDEAD_BEEF_0000_0001, 0, 0, 6'd40, 0);
        send_beat(64'hDEAD_BEEF_0000_0002, 0, 1, 6'd41, 1);
        check_stats();
        idle(2);

        // Single-beat broadcast.
        send_beat({48'hFFFF_FFFF_FFFF, 16'h0}, 1, 1, 6'd9, 1);
        check_stats();
        idle(2);

        // Unknown MAC.
        send_beat({48'h0200_0000_0001, 16'h0}, 1, 0, 6'd63, 0);
        send_beat(64'h0, 0, 1, 6'd1, 0);
        idle(2);
        check_stats();

        // FIFO fill and back-pressure.
        bus.tag_ready = 1'b0;
        for (int k = 0; k < 4; k++)
            send_beat({48'h0011_2233_4455, 16'(k)}, 1, 1, 6'(10 + k), 0);
        check("full_in_ready", bus.in_ready, 0);
        bus.in_data = {48'hFFFF_FFFF_FFFF, 16'h0}; bus.in_sop = 1'b1; bus.in_eop = 1'b1;
        bus.in_channel = 6'd20; bus.in_valid = 1'b1;
        idle(3);
        check("stall_in_ready", bus.in_ready, 0);
        check_stats();
        bus.tag_ready = 1'b1;
        send_beat({48'hFFFF_FFFF_FFFF, 16'h0}, 1, 1, 6'd20, 0);
        check_drained();
        check("in_ready_back", bus.in_ready, 1);
        check_stats();

        // Abandoned packet, then a stray eop.
        send_beat({48'h0011_2233_4455, 16'h0}, 1, 0, 6'd11, 0);
        send_beat(64'h1, 0, 0, 6'd12, 0);
        send_beat({48'hFFFF_FFFF_FFFF, 16'h0}, 1, 0, 6'd22, 0);
        send_beat(64'h2, 0, 1, 6'd23, 0);
        send_beat(64'h3, 0, 1, 6'd33, 0);
        check_drained();
        check_stats();

        // Table write coinciding with the sop lookup.
        cfg_wr = 1'b1; cfg_index = 3'd5; cfg_en = 1'b1; cfg_mac = 48'h0A0B_0C0D_0E0F; cfg_port = 2'd1;
        send_beat({48'h0A0B_0C0D_0E0F, 16'h0}, 1, 1, 6'd7, 0);
        m_en[5] = 1'b1; m_mac[5] = 48'h0A0B_0C0D_0E0F; m_port[5] = 2'd1;
        cfg_wr = 1'b0;
        send_beat({48'h0A0B_0C0D_0E0F, 16'h0}, 1, 1, 6'd8, 0);
        check_drained();
        check_stats();

        // Reset mid-packet with two tags queued.
        bus.tag_ready = 1'b0;
        send_beat({48'hFFFF_FFFF_FFFF, 16'h0}, 1, 1, 6'd1, 0);
        send_beat({48'h0A0B_0C0D_0E0F, 16'h0}, 1, 1, 6'd2, 0);
        send_beat({48'h0011_2233_4455, 16'h0}, 1, 0, 6'd3, 0);
        reset = 1'b0;
        #2;
        m_reset();
        check("mid_rst_tag_valid", bus.tag_valid, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        check_stats();
        @(posedge clock); #1;
        reset = 1'b1;
        bus.tag_ready = 1'b1;
        send_beat(64'h5, 0, 1, 6'd4, 0);
        cfg_write(2, 1'b1, 48'h0011_2233_4455, 2'd2);
        send_beat({48'h0011_2233_4455, 16'h0}, 1, 0, 6'd5, 0);
        send_beat(64'h6, 0, 1, 6'd6, 0);
        check_drained();
        check_stats();

        // Randomized traffic with duplicate table entries and random tag_ready.
        for (int i = 0; i < 4; i++) pool[i] = {16'($urandom), 32'($urandom)};
        for (int i = 0; i < NE; i++)
            cfg_write(i, ($urandom_range(0, 3) != 0), pool[i % 4], 2'($urandom));
        rand_rdy = 1'b1;
        for (int k = 0; k < 120; k++) begin
            int          sel;
            int          len;
            bit          abandon;
            logic [47:0] dst;
            sel = $urandom_range(0, 5);
            if (sel < 4)       dst = pool[sel];
            else if (sel == 4) dst = 48'hFFFF_FFFF_FFFF;
            else               dst = {16'($urandom), 32'($urandom)};
            len     = $urandom_range(1, 4);
            abandon = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0)
                send_beat({32'($urandom), 32'($urandom)}, 0, 1, 6'($urandom), 0);
            for (int b = 0; b < len; b++) begin
                d = {32'($urandom), 32'($urandom)};
                if (b == 0) d[63:16] = dst;
                send_beat(d, (b == 0), (b == len - 1) && !abandon, 6'($urandom), 0);
            end
            if ($urandom_range(0, 15) == 0)
                cfg_write($urandom_range(0, NE - 1), 1'($urandom), pool[$urandom_range(0, 3)], 2'($urandom));
        end
        rand_rdy = 1'b0;
        @(posedge clock); #2;
        bus.tag_ready = 1'b1;
        check_drained();
        check_stats();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mac_classifier.md
Name: mac_classifier

Overview:
- Sits directly upstream of the packet storage stage's tag input.
- Snoops the pass-through packet stream, which carries a 6-bit packet tag on its channel, and extracts the Ethernet destination MAC from the first beat.
- Resolves the destination MAC to a 2-bit egress interface using a small software-programmed MAC table.
- Emits one 8-bit tag {egress[1:0], tag[5:0]} per packet after its eop beat; tags queue in a small FIFO.

Parameters:
- NUM_ENTRIES, 8, number of MAC table entries (power of 2, 2..16).
- FIFO_DEPTH, 4, tag FIFO depth (power of 2).
- DEFAULT_PORT, 2'd0, egress interface used on a table miss.
- BCAST_PORT, 2'd3, egress interface used for destination ff:ff:ff:ff:ff:ff.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  64  packet beat; beat 0 bits [63:16] hold the destination MAC, with the first byte in [63:56].
- in_valid  in  1  beat valid.
- in_sop  in  1  start of packet.
- in_eop  in  1  end of packet.
- in_channel  in  6  packet tag.
- in_ready  out  1  block can accept a beat.
- tag_data  out  8  {egress[1:0], tag[5:0]}.
- tag_valid  out  1  tag available.
- tag_ready  in  1  downstream accepts the tag.
- cfg_wr  in  1  table write strobe.
- cfg_index  in  log2(NUM_ENTRIES)  entry to write.
- cfg_en  in  1  entry enable bit.
- cfg_mac  in  48  entry MAC.
- cfg_port  in  2  entry egress interface.
- stat_pkts  out  16  packets classified (saturating).
- stat_miss  out  16  table misses (saturating).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values:
  - in_ready=1, tag_valid=0, tag_data=0.
  - Counters 0, FIFO empty, FSM IDLE.
  - All table entries disabled.
- A beat is accepted when in_valid && in_ready.
- in_ready = !fifo_full. This is combinational from registered FIFO state only; it has no dependence on tag_ready.
- FSM:
  - IDLE --accepted beat with sop && !eop--> IN_PKT.
  - IN_PKT --accepted beat with eop--> IDLE.
  - On an accepted sop beat, the block registers in_channel and the lookup result.
- Lookup is a parallel compare of in_data[63:16] against all enabled entries. Decision order:
  - destination all-ones -> BCAST_PORT.
  - else lowest-index matching enabled entry -> that entry's cfg_port.
  - else DEFAULT_PORT, and the miss is counted.
- Tag push:
  - On the accepted eop beat of a packet whose sop was seen, push {egress, channel} into the FIFO.
  - A single-beat packet (sop && eop) classifies and pushes in the same cycle.
  - tag_valid rises the cycle after the eop beat, never in the same cycle. This guarantees the packet table was written before the tag is read.
- stat_pkts increments on each push; stat_miss increments on each push whose lookup missed. Both saturate at 16'hFFFF.
- Boundary conditions:
  - An accepted eop beat in IDLE without sop: dropped; no push, no count.
  - sop accepted while in IN_PKT: the previous packet is abandoned (no tag); the new sop restarts classification.
  - in_channel changing mid-packet: ignored; the sop-cycle value is used.
  - cfg_wr in the same cycle as a sop lookup: the lookup uses the pre-write table contents; the write is visible from the next cycle.
- FIFO:
  - Pop occurs on tag_valid && tag_ready.
  - Simultaneous push and pop when full is impossible because in_ready=0.
  - Simultaneous push and pop otherwise leaves the occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - tag_data/tag_valid are driven from the FIFO head.
- Reset asserted mid-packet or mid-FIFO discards all state immediately.

Decomposition:
- Package mac_classifier_pkg:
  - mac_t (48 bits), port_t (2), tag_t (6).
  - Packed struct tag_word_t {port_t, tag_t}.
  - Constant BCAST_MAC = 48'hFFFF_FFFF_FFFF.
  - FSM state enum {IDLE, IN_PKT}.
- Sub-module tag_fifo: parameterised synchronous FIFO (width 8, FIFO_DEPTH), with registered full/empty flags.
- The MAC table and compare stay inline in mac_classifier.

Test Plan:
- Program entry 2 = {en=1, mac=00:11:22:33:44:55, port=2}. Send a 3-beat packet with channel 6'd5 and beat-0 MAC 00:11:22:33:44:55 -> one tag 8'h85, tag_valid rises the cycle after eop, stat_pkts=1, stat_miss=0.
- Single-beat packet (sop && eop), destination ff:ff:ff:ff:ff:ff, channel 6'd9 -> tag 8'hC9 (BCAST_PORT=3), stat_miss=0.
- Unknown MAC 02:00:00:00:00:01, channel 6'd63 -> tag 8'h3F, stat_miss=1.
- Hold tag_ready=0 and send 5 packets -> after 4 pushes in_ready=0 and the 5th beat stalls. Release tag_ready -> tags pop in order, in_ready returns, the 5th tag is produced.
- Abandoned packet: sop, body, sop, eop -> exactly one tag, carrying the second packet's channel. A stray eop in IDLE -> no tag.
- cfg_wr enabling a matching entry in the same cycle as the sop -> that packet gets DEFAULT_PORT. The next packet gets the programmed port.
- Assert reset mid-packet with 2 tags queued -> tag_valid=0, in_ready=1, counters 0, and the next packet classifies normally.
